interval_meter: RTL and testbench

Measures the number of clock cycles between a rising edge on `start_in` and a later rising edge on `stop_in`. It is the measuring counterpart of the programmable timer: the timer turns a value into a delay, and this block turns a delay back into a value. Each result is presented on a ready/valid output and held until it is consumed. The block saturates at full scale and flags the overflow.

---
 rtl/interval_meter.sv | 140 ++++++++++++++
 tb/tb_interval_meter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_meter.sv
`default_nettype none
// ============================================================================
//  Module      : interval_meter
//  Description : Measures the number of clock cycles between a rising edge on
//                start_in and a later rising edge on stop_in. The result is
//                saturated at full scale, flagged on overflow, and held on a
//                ready/valid output until it is consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module interval_meter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             srst,
   input  logic             start_in,
   input  logic             stop_in,
   output logic [WIDTH-1:0] meas,
   output logic             overflow,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             busy
);

   localparam logic [WIDTH-1:0] c_max_count = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_one       = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_sticky;
   logic             r_start_prev;
   logic             r_stop_prev;
   logic [WIDTH-1:0] r_meas;
   logic             r_overflow;
   logic             r_meas_valid;
   logic             r_busy;

   logic             w_start_ev;
   logic             w_stop_ev;
   logic             w_at_max;
   logic [WIDTH-1:0] w_cnt_sat;

   // Rising-edge events and the saturating next count value.
   always_comb begin
      w_start_ev = start_in & ~r_start_prev;
      w_stop_ev  = stop_in  & ~r_stop_prev;
      w_at_max   = (r_count == c_max_count);
      w_cnt_sat  = w_at_max ? c_max_count : (r_count + c_one);
   end

   // Measurement FSM, counter, edge history and registered result outputs.
   // The previous-value registers reset high so that a level already present
   // when reset is released is not mistaken for a fresh edge.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_sticky     <= 1'b0;
         r_start_prev <= 1'b1;
         r_stop_prev  <= 1'b1;
         r_meas       <= '0;
         r_overflow   <= 1'b0;
         r_meas_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else if (srst) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_sticky     <= 1'b0;
         r_start_prev <= 1'b1;
         r_stop_prev  <= 1'b1;
         r_meas       <= '0;
         r_overflow   <= 1'b0;
         r_meas_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_start_prev <= start_in;
         r_stop_prev  <= stop_in;
         case (r_state)
            S_IDLE: begin
               // Stop events are meaningless here; a start always wins.
               if (w_start_ev) begin
                  r_count  <= '0;
                  r_sticky <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_MEASURE;
               end
            end
            S_MEASURE: begin
               if (w_stop_ev) begin
                  // The stop edge itself counts as the final cycle.
                  r_meas       <= w_cnt_sat;
                  r_overflow   <= w_at_max | r_sticky;
                  r_meas_valid <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_HOLD;
               end else if (w_start_ev) begin
                  r_count  <= '0;
                  r_sticky <= 1'b0;
               end else begin
                  r_count  <= w_cnt_sat;
                  r_sticky <= r_sticky | w_at_max;
               end
            end
            S_HOLD: begin
               // Result stays frozen until consumed; a start coinciding with
               // the handshake begins the next measurement immediately.
               if (meas_ready) begin
                  r_meas_valid <= 1'b0;
                  if (w_start_ev) begin
                     r_count  <= '0;
                     r_sticky <= 1'b0;
                     r_busy   <= 1'b1;
                     r_state  <= S_MEASURE;
                  end else begin
                     r_state  <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
               r_meas_valid <= 1'b0;
            end
         endcase
      end
   end

   assign meas       = r_meas;
   assign overflow   = r_overflow;
   assign meas_valid = r_meas_valid;
   assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_interval_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interval_meter
//  Description : Self-checking bench for interval_meter. Two instances
//                (WIDTH=8 and WIDTH=4) share one stimulus stream and are
//                compared against a timestamp-based reference model, a table
//                of hand-computed vectors and directed corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_meter;

   logic       clk = 1'b0;
   logic       arst = 1'b0;
   logic       srst = 1'b0;
   logic       start_in = 1'b0;
   logic       stop_in = 1'b0;
   logic       meas_ready = 1'b1;

   logic [7:0] meas8;
   logic       ovf8, valid8, busy8;
   logic [3:0] meas4;
   logic       ovf4, valid4, busy4;

   int n_checks = 0;
   int n_errors = 0;

   interval_meter #(.WIDTH(8)) dut8 (
      .clk(clk), .arst(arst), .srst(srst),
      .start_in(start_in), .stop_in(stop_in),
      .meas(meas8), .overflow(ovf8), .meas_valid(valid8),
      .meas_ready(meas_ready), .busy(busy8)
   );

   interval_meter #(.WIDTH(4)) dut4 (
      .clk(clk), .arst(arst), .srst(srst),
      .start_in(start_in), .stop_in(stop_in),
      .meas(meas4), .overflow(ovf4), .meas_valid(valid4),
      .meas_ready(meas_ready), .busy(busy4)
   );

   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1);
   end

   // ---------------- reference model (timestamps, not counters) ------------
   // lane 0 models WIDTH=8, lane 1 models WIDTH=4.
   int m_mode[2];     // 0 idle, 1 measuring, 2 holding a result
   int m_tstart[2];
   int m_meas[2];
   bit m_ovf[2];
   int m_max[2] = '{255, 15};
   bit m_ps, m_pp;
   int cyc = 0;

   function automatic void model_reset();
      for (int l = 0; l < 2; l++) begin
         m_mode[l] = 0; m_tstart[l] = 0; m_meas[l] = 0; m_ovf[l] = 1'b0;
      end
      m_ps = 1'b1; m_pp = 1'b1;
   endfunction

   function automatic void model_edge(input bit s, input bit p, input bit r);
      bit sev, pev;
      int n;
      cyc++;
      if (!arst || srst) begin
         model_reset();
         return;
      end
      sev = s && !m_ps;
      pev = p && !m_pp;
      m_ps = s; m_pp = p;
      for (int l = 0; l < 2; l++) begin
         case (m_mode[l])
            0: if (sev) begin m_mode[l] = 1; m_tstart[l] = cyc; end
            1: begin
               if (pev) begin
                  n = cyc - m_tstart[l];
                  m_meas[l] = (n > m_max[l]) ? m_max[l] : n;
                  m_ovf[l]  = (n > m_max[l]);
                  m_mode[l] = 2;
               end else if (sev) begin
                  m_tstart[l] = cyc;
               end
            end
            default: if (r) begin
               if (sev) begin m_mode[l] = 1; m_tstart[l] = cyc; end
               else m_mode[l] = 0;
            end
         endcase
      end
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_model();
      check("model meas w8",  int'(meas8),  m_meas[0]);
      check("model ovf w8",   int'(ovf8),   int'(m_ovf[0]));
      check("model valid w8", int'(valid8), int'(m_mode[0] == 2));
      check("model busy w8",  int'(busy8),  int'(m_mode[0] == 1));
      check("model meas w4",  int'(meas4),  m_meas[1]);
      check("model ovf w4",   int'(ovf4),   int'(m_ovf[1]));
      check("model valid w4", int'(valid4), int'(m_mode[1] == 2));
      check("model busy w4",  int'(busy4),  int'(m_mode[1] == 1));
   endtask

   // Drive one cycle of inputs, clock it, then compare just after the edge.
   task automatic step(input bit s, input bit p, input bit r);
      start_in = s; stop_in = p; meas_ready = r;
      @(posedge clk);
      model_edge(s, p, r);
      #1;
      compare_model();
   endtask

   // Start event, stop event N edges later, leaves the block in HOLD.
   task automatic measure(input int n, input bit r);
      step(1'b1, 1'b0, r);
      for (int k = 0; k < n - 1; k++) step(1'b0, 1'b0, r);
      step(1'b0, 1'b1, r);
   endtask

   typedef struct {
      bit s; bit p; bit r;
      int meas; bit valid; bit busy;
   } vec_t;

   vec_t tbl[20];

   initial begin
      // Hand-computed per-cycle vectors (overflow expected 0 throughout).
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1};
      tbl[17] = '{1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0};
      tbl[19] = '{1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0};

      model_reset();
      #1;
      check("reset meas",  int'(meas8),  0);
      check("reset valid", int'(valid8), 0);
      check("reset busy",  int'(busy4),  0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      arst = 1'b1;
      step(1'b0, 1'b0, 1'b1);

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].s, tbl[i].p, tbl[i].r);
         check($sformatf("tbl[%0d] meas w8", i),  int'(meas8),  tbl[i].meas);
         check($sformatf("tbl[%0d] meas w4", i),  int'(meas4),  tbl[i].meas);
         check($sformatf("tbl[%0d] valid", i),    int'(valid8), int'(tbl[i].valid));
         check($sformatf("tbl[%0d] busy", i),     int'(busy8),  int'(tbl[i].busy));
         check($sformatf("tbl[%0d] ovf", i),      int'(ovf8),   0);
      end
      step(1'b0, 1'b0, 1'b1);

      // ---------------- minimum and full scale ----------------
      measure(1, 1'b1);
      check("min meas", int'(meas8), 1);
      check("min valid", int'(valid8), 1);
      step(1'b0, 1'b0, 1'b1);
      check("min valid one cycle", int'(valid8), 0);
      measure(15, 1'b1);
      check("fs15 meas w4", int'(meas4), 15);
      check("fs15 ovf w4",  int'(ovf4), 0);
      step(1'b0, 1'b0, 1'b1);
      measure(20, 1'b1);
      check("n20 meas w4", int'(meas4), 15);
      check("n20 ovf w4",  int'(ovf4), 1);
      check("n20 meas w8", int'(meas8), 20);
      check("n20 ovf w8",  int'(ovf8), 0);
      step(1'b0, 1'b0, 1'b1);
      measure(255, 1'b1);
      check("fs255 meas w8", int'(meas8), 255);
      check("fs255 ovf w8",  int'(ovf8), 0);
      step(1'b0, 1'b0, 1'b1);
      measure(256, 1'b1);
      check("n256 meas w8", int'(meas8), 255);
      check("n256 ovf w8",  int'(ovf8), 1);
      step(1'b0, 1'b0, 1'b1);
      measure(300, 1'b1);
      check("n300 meas w8", int'(meas8), 255);
      check("n300 ovf w8",  int'(ovf8), 1);
      step(1'b0, 1'b0, 1'b1);

      // ---------------- restart ----------------
      step(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check("restart meas", int'(meas8), 6);
      check("restart ovf",  int'(ovf8), 0);
      step(1'b0, 1'b0, 1'b1);

      // ---------------- back-pressure ----------------
      measure(7, 1'b0);
      check("bp meas", int'(meas8), 7);
      for (int k = 0; k < 10; k++) begin
         step((k == 2 || k == 3 || k == 6 || k == 7), 1'b0, 1'b0);
         check("bp hold meas",  int'(meas8),  7);
         check("bp hold valid", int'(valid8), 1);
         check("bp hold busy",  int'(busy8),  0);
      end
      step(1'b1, 1'b0, 1'b1);
      check("bp handshake valid", int'(valid8), 0);
      check("bp handshake busy",  int'(busy8),  1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check("bp next meas", int'(meas8), 3);
      step(1'b0, 1'b0, 1'b1);

      // ---------------- collision in MEASURE ----------------
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("collide meas",  int'(meas8),  2);
      check("collide valid", int'(valid8), 1);
      step(1'b0, 1'b0, 1'b1);
      check("collide idle busy",  int'(busy8),  0);
      check("collide idle valid", int'(valid8), 0);
      step(1'b0, 1'b0, 1'b1);

      // ---------------- srst in HOLD ----------------
      measure(3, 1'b0);
      check("srst pre valid", int'(valid8), 1);
      srst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      check("srst valid", int'(valid8), 0);
      check("srst meas",  int'(meas8),  0);
      srst = 1'b0;
      step(1'b0, 1'b0, 1'b1);

      // ---------------- asynchronous reset mid-measurement ----------------
      measure(5, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check("arst pre busy", int'(busy8), 1);
      check("arst pre meas", int'(meas8), 5);
      #2 arst = 1'b0;
      #1;
      model_reset();
      check("arst busy",  int'(busy8),  0);
      check("arst valid", int'(valid8), 0);
      check("arst meas",  int'(meas8),  0);
      check("arst ovf",   int'(ovf8),   0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      arst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 1'b1);
         check("start held busy", int'(busy8), 0);
      end
      step(1'b0, 1'b0, 1'b1);

      // ---------------- randomized stimulus ----------------
      for (int k = 0; k < 4000; k++) begin
         srst = ($urandom_range(0, 299) == 0);
         step(($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 2) != 0));
      end
      srst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
